// File: rtl/ip_cksum_stream_pkg.sv
// Shared constants and types for the streaming IPv4 header checksum engine.
package ip_cksum_pkg;

  localparam int IHL_MIN        = 5;
  localparam int IHL_MAX        = 15;
  localparam int CKSUM_WORD_IDX = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    FOLD1 = 2'd2,
    FOLD2 = 2'd3
  } cks_state_t;

endpackage

// File: rtl/ip_cksum_stream_if.sv
// Header beat stream: valid/ready handshake with a first-beat marker.
interface ip_cksum_stream_if #(
  parameter int DATA_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic              s_first;
  logic [DATA_W-1:0] s_data;

  modport master (output s_valid, output s_first, output s_data, input s_ready);
  modport slave  (input s_valid, input s_first, input s_data, output s_ready);
endinterface

// File: rtl/ip_cksum_stream_beat_add.sv
// Masked 16-bit word sum of one header beat.
// Words past the end of the header (IHL*2 words) are dropped; the checksum
// field word is dropped from sum_masked. With IP_CKSUM_VERIFY_EN the
// sum_with_cks output keeps the checksum field for receive-side checking.
module ip_cksum_beat_add
  import ip_cksum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 24
) (
  input  logic [DATA_W-1:0] beat,
  input  logic [4:0]        beat_idx,
  input  logic [3:0]        ihl,
  output logic [ACC_W-1:0]  sum_masked
`ifdef IP_CKSUM_VERIFY_EN
  ,
  output logic [ACC_W-1:0]  sum_with_cks
`endif
);

  localparam int WPB = DATA_W / 16;

  logic [15:0] word;
  logic [7:0]  widx;

  // Add every in-header word of the beat, first word taken from the MSBs.
  always_comb begin
    sum_masked = '0;
`ifdef IP_CKSUM_VERIFY_EN
    sum_with_cks = '0;
`endif
    word = '0;
    widx = '0;
    for (int k = 0; k < WPB; k++) begin
      word = beat[DATA_W-1-16*k -: 16];
      widx = 8'(beat_idx) * 8'(WPB) + 8'(k);
      if (widx < {3'b000, ihl, 1'b0}) begin
`ifdef IP_CKSUM_VERIFY_EN
        sum_with_cks = sum_with_cks + ACC_W'(word);
`endif
        if (widx != 8'(CKSUM_WORD_IDX)) begin
          sum_masked = sum_masked + ACC_W'(word);
        end
      end
    end
  end

endmodule

// File: rtl/ip_cksum_stream.sv
// Streaming IPv4 header checksum engine.
// Accepts a header beat-by-beat, honours IHL, folds the ones'-complement sum
// in two cycles and pulses cks_valid with the checksum (field taken as zero).
// Build option: IP_CKSUM_VERIFY_EN adds a second accumulator that includes
// the received checksum field and the cks_ok result port.
module ip_cksum_stream
  import ip_cksum_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ACC_W  = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  ip_cksum_stream_if.slave     s,
  output logic                 cks_valid,
  output logic [15:0]          cks_value,
  output logic                 hdr_err
`ifdef IP_CKSUM_VERIFY_EN
  ,
  output logic                 cks_ok
`endif
);

  localparam int BYTES = DATA_W / 8;
  localparam int SHIFT = $clog2(BYTES);

  // Beats needed for a header of ihl 32-bit words: ceil(ihl*4 / BYTES).
  function automatic logic [4:0] beat_count(input logic [3:0] ihl);
    logic [6:0] t;
    t = {1'b0, ihl, 2'b00} + 7'(BYTES - 1);
    return 5'(t >> SHIFT);
  endfunction

  cks_state_t state, state_nxt;

  logic [3:0]       ihl_q;
  logic [4:0]       n_beats_q;
  logic [4:0]       beat_cnt_q;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] beat_sum;
  logic [15:0]      folded;
`ifdef IP_CKSUM_VERIFY_EN
  logic [ACC_W-1:0] acc_v;
  logic [ACC_W-1:0] beat_sum_v;
  logic [15:0]      folded_v;
`endif

  logic       take;
  logic       start;
  logic [3:0] in_ihl;
  logic       bad_ihl;
  logic       start_ok;
  logic       cont;
  logic       last_cont;
  logic       first_is_last;
  logic [4:0] cur_idx;
  logic [3:0] cur_ihl;
  logic       ready_nxt;
  logic       cks_valid_nxt;
  logic       hdr_err_nxt;

  assign take          = s.s_valid & s.s_ready;
  assign in_ihl        = s.s_data[DATA_W-5:DATA_W-8];
  assign bad_ihl       = in_ihl < 4'(IHL_MIN);
  assign start         = take & s.s_first;
  assign start_ok      = start & ~bad_ihl;
  assign cont          = take & ~s.s_first & (state == ACCUM);
  assign last_cont     = cont & ((beat_cnt_q + 5'd1) == n_beats_q);
  assign first_is_last = beat_count(in_ihl) == 5'd1;

  // A first beat always restarts at word 0 with its own IHL.
  assign cur_idx = s.s_first ? 5'd0 : beat_cnt_q;
  assign cur_ihl = s.s_first ? in_ihl : ihl_q;

  assign folded = acc[15:0] + {15'd0, acc[16]};
`ifdef IP_CKSUM_VERIFY_EN
  assign folded_v = acc_v[15:0] + {15'd0, acc_v[16]};
`endif

  ip_cksum_beat_add #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W)
  ) u_beat_add (
    .beat         (s.s_data),
    .beat_idx     (cur_idx),
    .ihl          (cur_ihl),
    .sum_masked   (beat_sum)
`ifdef IP_CKSUM_VERIFY_EN
    ,
    .sum_with_cks (beat_sum_v)
`endif
  );

  // State register and registered control outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      s.s_ready <= 1'b0;
      cks_valid <= 1'b0;
      hdr_err   <= 1'b0;
    end else begin
      state     <= state_nxt;
      s.s_ready <= ready_nxt;
      cks_valid <= cks_valid_nxt;
      hdr_err   <= hdr_err_nxt;
    end
  end

  // Next-state logic; a first beat in ACCUM abandons the current header.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, ACCUM: begin
        if (start) begin
          if (bad_ihl)            state_nxt = IDLE;
          else if (first_is_last) state_nxt = FOLD1;
          else                    state_nxt = ACCUM;
        end else if (last_cont) begin
          state_nxt = FOLD1;
        end
      end
      FOLD1:   state_nxt = FOLD2;
      FOLD2:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode, registered one cycle later by the state register.
  always_comb begin
    ready_nxt     = (state_nxt == IDLE) || (state_nxt == ACCUM);
    cks_valid_nxt = (state == FOLD2);
    hdr_err_nxt   = start & bad_ihl;
  end

  // Header bookkeeping, accumulation and the two fold steps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ihl_q      <= '0;
      n_beats_q  <= '0;
      beat_cnt_q <= '0;
      acc        <= '0;
      cks_value  <= '0;
`ifdef IP_CKSUM_VERIFY_EN
      acc_v      <= '0;
      cks_ok     <= 1'b0;
`endif
    end else if (start_ok) begin
      ihl_q      <= in_ihl;
      n_beats_q  <= beat_count(in_ihl);
      beat_cnt_q <= 5'd1;
      acc        <= beat_sum;
`ifdef IP_CKSUM_VERIFY_EN
      acc_v      <= beat_sum_v;
`endif
    end else if (cont) begin
      beat_cnt_q <= beat_cnt_q + 5'd1;
      acc        <= acc + beat_sum;
`ifdef IP_CKSUM_VERIFY_EN
      acc_v      <= acc_v + beat_sum_v;
`endif
    end else if (state == FOLD1) begin
      acc        <= ACC_W'(acc[15:0]) + ACC_W'(acc[ACC_W-1:16]);
`ifdef IP_CKSUM_VERIFY_EN
      acc_v      <= ACC_W'(acc_v[15:0]) + ACC_W'(acc_v[ACC_W-1:16]);
`endif
    end else if (state == FOLD2) begin
      acc        <= ACC_W'(folded);
      cks_value  <= ~folded;
`ifdef IP_CKSUM_VERIFY_EN
      acc_v      <= ACC_W'(folded_v);
      cks_ok     <= (folded_v == 16'hFFFF);
`endif
    end
  end

endmodule
